// File: rtl/nvdla_cmac_pwr_ctrl_pkg.sv
// Shared types and constants for the CMAC Q-channel power controller.
// Also holds the qreqn decode, so every user derives qreqn from the state the same way.
package nvdla_cmac_pwr_pkg;

  localparam int PD_W   = 63;
  localparam int DENY_W = 8;

  typedef enum logic [2:0] {
    PWR_RUN    = 3'd0,
    PWR_REQ    = 3'd1,
    PWR_STOP   = 3'd2,
    PWR_WAKE   = 3'd3,
    PWR_DENIED = 3'd4
  } pwr_state_e;

  // qreqn is low only while quiescence is being requested or held.
  function automatic logic pwr_qreqn(input logic [2:0] st);
    return !((st == PWR_REQ) || (st == PWR_STOP));
  endfunction

endpackage

// File: rtl/nvdla_cmac_pwr_ctrl_if.sv
// Bundles the CSB forwarding path, CMAC activity inputs, Q-channel and status signals.
// The master modport is the controller's view; slave is the surrounding environment.
interface nvdla_cmac_pwr_ctrl_if;
  import nvdla_cmac_pwr_pkg::*;

  logic              pwr_en;
  logic              csb_req_pvld;
  logic              csb_req_prdy;
  logic [PD_W-1:0]   csb_req_pd;
  logic              cmac_req_pvld;
  logic              cmac_req_prdy;
  logic [PD_W-1:0]   cmac_req_pd;
  logic              cmac_resp_valid;
  logic              reg2dp_op_en;
  logic              qreqn;
  logic              qacceptn;
  logic              qdeny;
  logic [2:0]        pwr_state;
  logic [DENY_W-1:0] deny_cnt;
  logic              proto_err;

  modport master (
    input  pwr_en, csb_req_pvld, csb_req_pd, cmac_req_prdy,
           cmac_resp_valid, reg2dp_op_en, qacceptn, qdeny,
    output csb_req_prdy, cmac_req_pvld, cmac_req_pd, qreqn,
           pwr_state, deny_cnt, proto_err
  );

  modport slave (
    output pwr_en, csb_req_pvld, csb_req_pd, cmac_req_prdy,
           cmac_resp_valid, reg2dp_op_en, qacceptn, qdeny,
    input  csb_req_prdy, cmac_req_pvld, cmac_req_pd, qreqn,
           pwr_state, deny_cnt, proto_err
  );

endinterface

// File: rtl/nvdla_cmac_pwr_ctrl_idle_timer.sv
// Counts consecutive idle cycles and flags the cycle in which the idle window completes.
// The count restarts on any busy cycle, on expiry, or while clr_i is held.
module nvdla_cmac_idle_timer #(
  parameter int IDLE_W      = 8,
  parameter int IDLE_THRESH = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic idle_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam logic [IDLE_W-1:0] LAST_CNT = IDLE_W'(IDLE_THRESH - 1);

  logic [IDLE_W-1:0] cnt_q;
  logic [IDLE_W-1:0] cnt_d;

  assign expire_o = idle_i & ~clr_i & (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || !idle_i || expire_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nvdla_cmac_pwr_ctrl.sv
// Q-channel master for CMAC: requests quiescence after an idle window, wakes on CSB traffic
// or software disable, and only lets CSB requests through while the device is running.
module nvdla_cmac_pwr_ctrl
  import nvdla_cmac_pwr_pkg::*;
#(
  parameter int IDLE_W      = 8,
  parameter int IDLE_THRESH = 16
) (
  input  logic                         nvdla_core_clk,
  input  logic                         nvdla_core_rst,
  nvdla_cmac_pwr_ctrl_if.master        pwr_if
);

  localparam logic [2:0] ST_RUN    = PWR_RUN;
  localparam logic [2:0] ST_REQ    = PWR_REQ;
  localparam logic [2:0] ST_STOP   = PWR_STOP;
  localparam logic [2:0] ST_WAKE   = PWR_WAKE;
  localparam logic [2:0] ST_DENIED = PWR_DENIED;

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [DENY_W-1:0] deny_cnt_q;
  logic [DENY_W-1:0] deny_cnt_d;
  logic              proto_err_q;
  logic              proto_err_d;
  logic              in_run;
  logic              idle;
  logic              idle_expire;

  assign in_run = (state_q == ST_RUN);
  assign idle   = pwr_if.pwr_en & ~pwr_if.csb_req_pvld &
                  ~pwr_if.cmac_resp_valid & ~pwr_if.reg2dp_op_en;

  // Requests outside RUN are back-pressured rather than dropped.
  assign pwr_if.cmac_req_pvld = pwr_if.csb_req_pvld & in_run;
  assign pwr_if.csb_req_prdy  = pwr_if.cmac_req_prdy & in_run;
  assign pwr_if.cmac_req_pd   = pwr_if.csb_req_pd;

  assign pwr_if.qreqn     = pwr_qreqn(state_q);
  assign pwr_if.pwr_state = state_q;
  assign pwr_if.deny_cnt  = deny_cnt_q;
  assign pwr_if.proto_err = proto_err_q;

  // Held clear outside RUN so every entry into RUN starts a fresh idle window.
  nvdla_cmac_idle_timer #(
    .IDLE_W      (IDLE_W),
    .IDLE_THRESH (IDLE_THRESH)
  ) u_idle_timer (
    .clk_i    (nvdla_core_clk),
    .rst_i    (nvdla_core_rst),
    .idle_i   (idle),
    .clr_i    (~in_run),
    .expire_o (idle_expire)
  );

  always_comb begin
    state_d     = state_q;
    deny_cnt_d  = deny_cnt_q;
    proto_err_d = proto_err_q;
    case (state_q)
      ST_RUN: begin
        if (pwr_if.qdeny) proto_err_d = 1'b1;
        if (idle_expire)  state_d     = ST_REQ;
      end
      ST_REQ: begin
        // A simultaneous deny and accept is illegal; the deny is honoured.
        if (pwr_if.qdeny) begin
          state_d = ST_DENIED;
          if (deny_cnt_q != {DENY_W{1'b1}}) deny_cnt_d = deny_cnt_q + 1'b1;
          if (!pwr_if.qacceptn) proto_err_d = 1'b1;
        end else if (!pwr_if.qacceptn) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (pwr_if.qacceptn) proto_err_d = 1'b1;
        if (pwr_if.csb_req_pvld || !pwr_if.pwr_en) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        if (pwr_if.qacceptn) state_d = ST_RUN;
      end
      ST_DENIED: begin
        if (!pwr_if.qdeny) state_d = ST_RUN;
      end
      default: state_d = ST_WAKE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q     <= ST_WAKE;
      deny_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      deny_cnt_q  <= deny_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_nvdla_cmac_pwr_ctrl.sv
// Self-checking bench for nvdla_cmac_pwr_ctrl: directed scenarios plus a randomized run,
// all compared against a cycle-level behavioural model of the power controller.
module tb_nvdla_cmac_pwr_ctrl;

  localparam int S_RUN = 0, S_REQ = 1, S_STOP = 2, S_WAKE = 3, S_DENIED = 4;
  localparam int WINDOW = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   autoQ;

  int   mState;
  int   mIdleRun;
  int   mDenies;
  bit   mProto;

  nvdla_cmac_pwr_ctrl_if pwr_if ();

  nvdla_cmac_pwr_ctrl #(
    .IDLE_W      (8),
    .IDLE_THRESH (WINDOW)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .pwr_if         (pwr_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit mQreqn();
    return !((mState == S_REQ) || (mState == S_STOP));
  endfunction

  function automatic logic [7:0] mDenyCnt();
    return (mDenies > 255) ? 8'd255 : 8'(mDenies);
  endfunction

  // Applies one clock edge worth of the controller's rules to the model.
  task automatic modelEdge();
    bit idleNow;
    idleNow = pwr_if.pwr_en && !pwr_if.csb_req_pvld && !pwr_if.cmac_resp_valid && !pwr_if.reg2dp_op_en;
    if (rst) begin
      mState = S_WAKE; mIdleRun = 0; mDenies = 0; mProto = 0;
    end else begin
      case (mState)
        S_RUN: begin
          if (pwr_if.qdeny) mProto = 1;
          if (idleNow) begin
            mIdleRun++;
            if (mIdleRun >= WINDOW) begin mState = S_REQ; mIdleRun = 0; end
          end else mIdleRun = 0;
        end
        S_REQ: begin
          if (pwr_if.qdeny) begin
            if (!pwr_if.qacceptn) mProto = 1;
            mDenies++;
            mState = S_DENIED;
          end else if (!pwr_if.qacceptn) mState = S_STOP;
        end
        S_STOP: begin
          if (pwr_if.qacceptn) mProto = 1;
          if (pwr_if.csb_req_pvld || !pwr_if.pwr_en) mState = S_WAKE;
        end
        S_WAKE:   if (pwr_if.qacceptn) begin mState = S_RUN; mIdleRun = 0; end
        default:  if (!pwr_if.qdeny)   begin mState = S_RUN; mIdleRun = 0; end
      endcase
    end
  endtask

  task automatic step();
    modelEdge();
    @(posedge clk);
    #1;
    if (autoQ) pwr_if.qacceptn = mQreqn();
  endtask

  task automatic applyStimulus(input bit en, input bit pvld, input bit resp, input bit op);
    pwr_if.pwr_en          = en;
    pwr_if.csb_req_pvld    = pvld;
    pwr_if.cmac_resp_valid = resp;
    pwr_if.reg2dp_op_en    = op;
  endtask

  task automatic goRun();
    int n;
    autoQ = 1;
    pwr_if.qdeny = 0;
    pwr_if.qacceptn = mQreqn();
    applyStimulus(0, 0, 0, 0);
    n = 0;
    while (mState != S_RUN && n < 20) begin step(); n++; end
    pwr_if.pwr_en = 1;
    checks++;
    if (mState != S_RUN || pwr_if.pwr_state !== 3'd0) begin
      errors++;
      $display("[TB] FAIL go_run: pwr_state=%0d expected 0 after %0d cycles", pwr_if.pwr_state, n);
    end
  endtask

  task automatic goReq();
    int n;
    applyStimulus(1, 0, 0, 0);
    n = 0;
    while (mState != S_REQ && n < 40) begin step(); n++; end
    checks++;
    if (mState != S_REQ || pwr_if.pwr_state !== 3'd1) begin
      errors++;
      $display("[TB] FAIL go_req: pwr_state=%0d expected 1 after %0d cycles", pwr_if.pwr_state, n);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    step();
    checks += 4;
    if (pwr_if.pwr_state !== 3'd3) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 3", pwr_if.pwr_state); end
    if (pwr_if.qreqn !== 1'b1)     begin errors++; $display("[TB] FAIL reset_qreqn: got %b expected 1", pwr_if.qreqn); end
    if (pwr_if.deny_cnt !== 8'd0)  begin errors++; $display("[TB] FAIL reset_deny: got %0d expected 0", pwr_if.deny_cnt); end
    if (pwr_if.proto_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_proto: got %b expected 0", pwr_if.proto_err); end
    rst = 0;
  endtask

  task automatic test_idle_powerdown();
    int n;
    applyStimulus(1, 0, 0, 0);
    step();
    checks++;
    if (pwr_if.pwr_state !== 3'd0) begin errors++; $display("[TB] FAIL wake_to_run: got %0d expected 0", pwr_if.pwr_state); end
    n = 0;
    while (pwr_if.qreqn === 1'b1 && n < 40) begin step(); n++; end
    checks += 2;
    if (n != WINDOW) begin errors++; $display("[TB] FAIL idle_window: qreqn fell after %0d cycles expected %0d", n, WINDOW); end
    if (pwr_if.pwr_state !== 3'd1) begin errors++; $display("[TB] FAIL idle_req: got %0d expected 1", pwr_if.pwr_state); end
    step();
    checks++;
    if (pwr_if.pwr_state !== 3'd2) begin errors++; $display("[TB] FAIL accept_stop: got %0d expected 2", pwr_if.pwr_state); end
  endtask

  task automatic test_wake_on_request();
    pwr_if.csb_req_pd    = 63'h1234;
    pwr_if.cmac_req_prdy = 1;
    pwr_if.csb_req_pvld  = 1;
    #1;
    checks += 2;
    if (pwr_if.cmac_req_pvld !== 1'b0) begin errors++; $display("[TB] FAIL stop_gate_pvld: got %b expected 0", pwr_if.cmac_req_pvld); end
    if (pwr_if.csb_req_prdy !== 1'b0)  begin errors++; $display("[TB] FAIL stop_gate_prdy: got %b expected 0", pwr_if.csb_req_prdy); end
    step();
    checks += 3;
    if (pwr_if.pwr_state !== 3'd3)     begin errors++; $display("[TB] FAIL req_wake: got %0d expected 3", pwr_if.pwr_state); end
    if (pwr_if.qreqn !== 1'b1)         begin errors++; $display("[TB] FAIL wake_qreqn: got %b expected 1", pwr_if.qreqn); end
    if (pwr_if.cmac_req_pvld !== 1'b0) begin errors++; $display("[TB] FAIL wake_gate_pvld: got %b expected 0", pwr_if.cmac_req_pvld); end
    step();
    checks += 4;
    if (pwr_if.pwr_state !== 3'd0)          begin errors++; $display("[TB] FAIL wake_run: got %0d expected 0", pwr_if.pwr_state); end
    if (pwr_if.cmac_req_pvld !== 1'b1)      begin errors++; $display("[TB] FAIL run_fwd_pvld: got %b expected 1", pwr_if.cmac_req_pvld); end
    if (pwr_if.cmac_req_pd !== 63'h1234)    begin errors++; $display("[TB] FAIL run_fwd_pd: got %h expected 1234", pwr_if.cmac_req_pd); end
    if (pwr_if.csb_req_prdy !== 1'b1)       begin errors++; $display("[TB] FAIL run_prdy_hi: got %b expected 1", pwr_if.csb_req_prdy); end
    pwr_if.cmac_req_prdy = 0;
    #1;
    checks++;
    if (pwr_if.csb_req_prdy !== 1'b0) begin errors++; $display("[TB] FAIL run_prdy_lo: got %b expected 0", pwr_if.csb_req_prdy); end
    pwr_if.cmac_req_prdy = 1;
    pwr_if.csb_req_pvld  = 0;
  endtask

  task automatic test_activity_restart();
    int n;
    int early;
    early = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pwr_if.qreqn !== 1'b1) early++;
    end
    pwr_if.csb_req_pvld = 1;
    step();
    if (pwr_if.qreqn !== 1'b1) early++;
    pwr_if.csb_req_pvld = 0;
    n = 0;
    while (pwr_if.qreqn === 1'b1 && n < 40) begin step(); n++; end
    checks += 2;
    if (early != 0) begin errors++; $display("[TB] FAIL restart_early: qreqn low in %0d cycles expected 0", early); end
    if (n != WINDOW) begin errors++; $display("[TB] FAIL restart_window: qreqn fell after %0d cycles expected %0d", n, WINDOW); end
  endtask

  task automatic test_deny();
    goRun();
    autoQ = 0;
    pwr_if.qacceptn = 1;
    goReq();
    pwr_if.qdeny = 1;
    step();
    checks += 4;
    if (pwr_if.pwr_state !== 3'd4) begin errors++; $display("[TB] FAIL deny_state: got %0d expected 4", pwr_if.pwr_state); end
    if (pwr_if.deny_cnt !== 8'd1)  begin errors++; $display("[TB] FAIL deny_cnt1: got %0d expected 1", pwr_if.deny_cnt); end
    if (pwr_if.qreqn !== 1'b1)     begin errors++; $display("[TB] FAIL deny_qreqn: got %b expected 1", pwr_if.qreqn); end
    if (pwr_if.proto_err !== 1'b0) begin errors++; $display("[TB] FAIL deny_proto: got %b expected 0", pwr_if.proto_err); end
    pwr_if.qdeny = 0;
    step();
    checks++;
    if (pwr_if.pwr_state !== 3'd0) begin errors++; $display("[TB] FAIL deny_release: got %0d expected 0", pwr_if.pwr_state); end
  endtask

  task automatic test_deny_saturate();
    logic [7:0] expCnt;
    for (int i = 2; i <= 300; i++) begin
      goReq();
      pwr_if.qdeny = 1;
      step();
      pwr_if.qdeny = 0;
      step();
      if (i == 254 || i == 255 || i == 256 || i == 300) begin
        expCnt = (i > 255) ? 8'd255 : 8'(i);
        checks++;
        if (pwr_if.deny_cnt !== expCnt) begin
          errors++; $display("[TB] FAIL deny_sat_%0d: got %0d expected %0d", i, pwr_if.deny_cnt, expCnt);
        end
      end
    end
    checks++;
    if (pwr_if.deny_cnt !== mDenyCnt()) begin errors++; $display("[TB] FAIL deny_sat_model: got %0d expected %0d", pwr_if.deny_cnt, mDenyCnt()); end
  endtask

  task automatic test_proto_err();
    goRun();
    autoQ = 0;
    pwr_if.qacceptn = 1;
    goReq();
    pwr_if.qdeny = 1;
    pwr_if.qacceptn = 0;
    step();
    checks += 2;
    if (pwr_if.pwr_state !== 3'd4) begin errors++; $display("[TB] FAIL proto_state: got %0d expected 4", pwr_if.pwr_state); end
    if (pwr_if.proto_err !== 1'b1) begin errors++; $display("[TB] FAIL proto_set: got %b expected 1", pwr_if.proto_err); end
    pwr_if.qdeny = 0;
    pwr_if.qacceptn = 1;
    applyStimulus(1, 1, 0, 0);
    for (int i = 0; i < 20; i++) step();
    checks += 2;
    if (pwr_if.pwr_state !== 3'd0) begin errors++; $display("[TB] FAIL proto_run: got %0d expected 0", pwr_if.pwr_state); end
    if (pwr_if.proto_err !== 1'b1) begin errors++; $display("[TB] FAIL proto_sticky: got %b expected 1", pwr_if.proto_err); end
    pwr_if.csb_req_pvld = 0;
  endtask

  task automatic test_mid_reset();
    goRun();
    goReq();
    step();
    checks++;
    if (pwr_if.pwr_state !== 3'd2) begin errors++; $display("[TB] FAIL midrst_stop: got %0d expected 2", pwr_if.pwr_state); end
    rst = 1;
    step();
    rst = 0;
    checks += 4;
    if (pwr_if.pwr_state !== 3'd3) begin errors++; $display("[TB] FAIL midrst_state: got %0d expected 3", pwr_if.pwr_state); end
    if (pwr_if.qreqn !== 1'b1)     begin errors++; $display("[TB] FAIL midrst_qreqn: got %b expected 1", pwr_if.qreqn); end
    if (pwr_if.deny_cnt !== 8'd0)  begin errors++; $display("[TB] FAIL midrst_deny: got %0d expected 0", pwr_if.deny_cnt); end
    if (pwr_if.proto_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_proto: got %b expected 0", pwr_if.proto_err); end
  endtask

  task automatic test_sw_disable();
    goRun();
    pwr_if.pwr_en = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if (pwr_if.qreqn !== 1'b1) begin errors++; $display("[TB] FAIL swdis_qreqn_%0d: got %b expected 1", i, pwr_if.qreqn); end
    end
    pwr_if.pwr_en = 1;
  endtask

  task automatic test_random();
    bit expPvld;
    autoQ = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus($urandom_range(0, 19) != 0, $urandom_range(0, 24) == 0,
                    $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0);
      pwr_if.csb_req_pd    = 63'({$urandom(), $urandom()});
      pwr_if.cmac_req_prdy = 1'($urandom_range(0, 1));
      case (mState)
        S_REQ:    pwr_if.qdeny = ($urandom_range(0, 3) == 0);
        S_DENIED: pwr_if.qdeny = ($urandom_range(0, 1) == 0);
        default:  pwr_if.qdeny = ($urandom_range(0, 299) == 0);
      endcase
      if (mState == S_REQ || mState == S_WAKE) pwr_if.qacceptn = 1'($urandom_range(0, 1));
      else pwr_if.qacceptn = mQreqn() ^ ($urandom_range(0, 299) == 0);
      #1;
      expPvld = pwr_if.csb_req_pvld && (mState == S_RUN);
      checks += 3;
      if (pwr_if.cmac_req_pvld !== expPvld) begin errors++; $display("[TB] FAIL rnd_pvld_%0d: got %b expected %b", i, pwr_if.cmac_req_pvld, expPvld); end
      if (pwr_if.csb_req_prdy !== (pwr_if.cmac_req_prdy && (mState == S_RUN))) begin
        errors++; $display("[TB] FAIL rnd_prdy_%0d: got %b expected %b", i, pwr_if.csb_req_prdy, pwr_if.cmac_req_prdy && (mState == S_RUN));
      end
      if (pwr_if.cmac_req_pd !== pwr_if.csb_req_pd) begin errors++; $display("[TB] FAIL rnd_pd_%0d: got %h expected %h", i, pwr_if.cmac_req_pd, pwr_if.csb_req_pd); end
      step();
      checks += 4;
      if (pwr_if.pwr_state !== 3'(mState)) begin errors++; $display("[TB] FAIL rnd_state_%0d: got %0d expected %0d", i, pwr_if.pwr_state, mState); end
      if (pwr_if.qreqn !== mQreqn())       begin errors++; $display("[TB] FAIL rnd_qreqn_%0d: got %b expected %b", i, pwr_if.qreqn, mQreqn()); end
      if (pwr_if.deny_cnt !== mDenyCnt())  begin errors++; $display("[TB] FAIL rnd_deny_%0d: got %0d expected %0d", i, pwr_if.deny_cnt, mDenyCnt()); end
      if (pwr_if.proto_err !== mProto)     begin errors++; $display("[TB] FAIL rnd_proto_%0d: got %b expected %b", i, pwr_if.proto_err, mProto); end
    end
    rst = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    autoQ  = 1;
    mState = S_WAKE; mIdleRun = 0; mDenies = 0; mProto = 0;
    rst = 1;
    applyStimulus(1, 0, 0, 0);
    pwr_if.csb_req_pd    = '0;
    pwr_if.cmac_req_prdy = 1;
    pwr_if.qacceptn      = 1;
    pwr_if.qdeny         = 0;
    #1;
    $display("[TB] starting directed scenarios");
    test_reset();
    test_idle_powerdown();
    test_wake_on_request();
    test_activity_restart();
    test_deny();
    test_deny_saturate();
    test_proto_err();
    test_mid_reset();
    test_sw_disable();
    $display("[TB] starting randomized run");
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nvdla_cmac_pwr_ctrl.md
Name: nvdla_cmac_pwr_ctrl

Overview:
- Q-channel power controller (Q-channel master) sitting between the CSB request source and the CMAC Q-channel wrapper.
- Watches CMAC activity and, after a programmable idle window, requests quiescence (qreqn low).
- Completes the accept/deny handshake, then wakes the device when a new CSB request arrives or software disables auto power-down.
- Gates CSB request forwarding so requests reach CMAC only while granted.

Parameters:
- IDLE_W, 8, width of idle counter.
- IDLE_THRESH, 16, consecutive idle cycles (1..2^IDLE_W-1) required before qreqn is dropped.

Ports:
- nvdla_core_clk  in  1  sole clock
- nvdla_core_rst  in  1  reset; one clock; reset is synchronous and active-high
- pwr_en  in  1  software enable for automatic power-down
- csb_req_pvld  in  1  upstream CSB request valid
- csb_req_prdy  out  1  upstream CSB request ready
- csb_req_pd  in  63  upstream CSB request payload
- cmac_req_pvld  out  1  request valid to CMAC wrapper
- cmac_req_prdy  in  1  CMAC wrapper ready
- cmac_req_pd  out  63  payload to CMAC wrapper (= csb_req_pd, pure wire)
- cmac_resp_valid  in  1  CMAC CSB response valid (activity)
- reg2dp_op_en  in  1  CMAC operation enabled (activity)
- qreqn  out  1  Q-channel quiescence request, active-low
- qacceptn  in  1  Q-channel accept, active-low
- qdeny  in  1  Q-channel deny
- pwr_state  out  3  current FSM state encoding
- deny_cnt  out  8  saturating count of denies
- proto_err  out  1  sticky Q-channel protocol violation flag

Behaviour:
- State encodings: RUN=0, REQ=1, STOP=2, WAKE=3, DENIED=4. All state and flag registers update on the rising edge of nvdla_core_clk.
- qreqn output by state: 1 in RUN, WAKE and DENIED; 0 in REQ and STOP. qreqn is registered-state decode.
- Reset values (nvdla_core_rst=1 sampled at an edge): state=WAKE, qreqn=1, idle_cnt=0, deny_cnt=0, proto_err=0.
- Reset taken mid-handshake, including from STOP or REQ, returns to WAKE the next cycle. No handshake completion is required.
- Forwarding is combinational, zero latency:
  - cmac_req_pvld = csb_req_pvld & (state==RUN)
  - csb_req_prdy = cmac_req_prdy & (state==RUN)
  - Outside RUN, requests are held upstream and never dropped.
- idle = pwr_en & !csb_req_pvld & !cmac_resp_valid & !reg2dp_op_en.
- RUN:
  - idle_cnt increments when idle and clears to 0 on any non-idle cycle.
  - If idle and idle_cnt==IDLE_THRESH-1, go to REQ and clear idle_cnt.
  - A request arriving in the same cycle blocks the transition, because idle is false.
- REQ: qreqn=0, hold until the Q-channel responds.
  - qdeny=1: go to DENIED and increment deny_cnt (saturates at 255).
  - Else qacceptn=0: go to STOP.
  - If qdeny=1 and qacceptn=0 in the same cycle: deny wins and proto_err is set.
  - New requests or pwr_en=0 do not abort REQ.
- STOP: if csb_req_pvld | !pwr_en, go to WAKE; otherwise remain.
- WAKE: go to RUN when qacceptn=1 is sampled, clearing idle_cnt.
- DENIED: qreqn=1; go to RUN when qdeny=0 is sampled, clearing idle_cnt.
- Other proto_err triggers:
  - qacceptn=1 seen while in STOP.
  - qdeny=1 seen in RUN.
  - proto_err stays set until reset.
- pwr_en=0 while in RUN holds idle_cnt at 0, which prevents power-down.

Decomposition:
- Package nvdla_cmac_pwr_pkg holds:
  - state enum and encodings
  - PD_W=63 constant
  - DENY_W=8 constant
- One sub-module: nvdla_cmac_idle_timer. Inputs idle and clr; output expire at IDLE_THRESH-1; parameterized by IDLE_W and IDLE_THRESH.
- The FSM, forwarding gates and deny/proto_err logic live in the top module.

Test Plan:
- Reset then idle:
  - Stimulus: pwr_en=1, model raises qacceptn 1 cycle after qreqn rises.
  - Required response: WAKE, then RUN; after exactly 16 idle cycles qreqn=0 (REQ); after qacceptn=0, pwr_state=2 (STOP).
- Activity restart:
  - Stimulus: csb_req_pvld pulsed at idle_cnt=10.
  - Required response: counter clears; qreqn stays 1 until 16 further idle cycles elapse.
- Wake on request:
  - Stimulus: csb_req_pvld=1 in STOP with pd=0x1234.
  - Required response: next cycle WAKE and qreqn=1; cmac_req_pvld=0 until RUN; then cmac_req_pd=0x1234 forwarded; prdy follows cmac_req_prdy.
- Deny path:
  - Stimulus: qdeny=1 in REQ.
  - Required response: DENIED, deny_cnt=1, qreqn=1; after qdeny=0 → RUN.
  - Stimulus: 300 denies.
  - Required response: deny_cnt=255.
- Protocol error:
  - Stimulus: qdeny=1 with qacceptn=0 in REQ.
  - Required response: DENIED, proto_err=1, sticky until nvdla_core_rst.
- Mid-operation reset:
  - Stimulus: nvdla_core_rst=1 during STOP.
  - Required response: next cycle pwr_state=3, qreqn=1, deny_cnt=0, proto_err=0.
- Software disable:
  - Stimulus: pwr_en=0 in RUN for 100 cycles.
  - Required response: qreqn remains 1.
